// File: rtl/button_event_queue.sv
// Four-button debouncer feeding a memory-mapped event FIFO (STATUS / EVENT registers).
// Optional: BUTTON_RELEASE_EVENTS_EN also queues release events (kind 0).
module button_event_queue #(
   parameter int          DebounceCycles = 250000,
   parameter int          Depth          = 8,
   parameter logic [15:0] BaseAddr       = 16'hFF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  button,
   input  logic        readEnable,
   input  logic [15:0] readAddr,
   output logic [15:0] readData,
   output logic        readValid,
   input  logic        writeEnable,
   input  logic [15:0] writeAddr,
   input  logic [15:0] writeData,
   output logic        eventPending
);

   localparam int          CW        = $clog2(DebounceCycles);
   localparam int          AW        = $clog2(Depth);
   localparam logic [CW-1:0] CntLast = CW'(DebounceCycles - 1);
   localparam logic [15:0] EventAddr = BaseAddr + 16'd1;

   logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic [3:0]    stable_q, stable_d;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];
   logic [3:0]    pend_q, pend_d, kind_q, kind_d;
   logic [2:0]    mem_q [Depth];
   logic [2:0]    mem_d [Depth];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;

   logic          found, pop, push, drop, full;
   logic [1:0]    sel;
   logic          unused_wdata;

   assign unused_wdata = ^{writeData[15:8], writeData[6:0]};

   always_comb begin
      sync1_d  = button;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      kind_d   = kind_q;
      mem_d    = mem_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      found    = 1'b0;
      sel      = 2'd0;

      // A toggle is visible to the enqueue arbiter in the same cycle it happens.
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            stable_d[i] = ~stable_q[i];
            cnt_d[i]    = '0;
`ifdef BUTTON_RELEASE_EVENTS_EN
            pend_d[i] = 1'b1;
            kind_d[i] = ~stable_q[i];
`else
            if (!stable_q[i]) begin
               pend_d[i] = 1'b1;
               kind_d[i] = 1'b1;
            end
`endif
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end

      for (int i = 0; i < 4; i++) begin
         if (pend_d[i] && !found) begin
            found = 1'b1;
            sel   = 2'(i);
         end
      end

      full = (count_q == (AW+1)'(Depth));
      pop  = readEnable && (readAddr == EventAddr) && (count_q != '0);
      push = found && (!full || pop);
      drop = found && full && !pop;

      if (found) pend_d[sel] = 1'b0;
      if (push) begin
         mem_d[wr_q] = {kind_d[sel], sel};
         wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      // Set beats clear when both land in the same cycle.
      if (writeEnable && (writeAddr == BaseAddr) && writeData[7]) ovf_d = 1'b0;
      if (drop) ovf_d = 1'b1;

      if (readEnable && (readAddr == BaseAddr)) begin
         rvalid_d = 1'b1;
         rdata_d  = {8'b0, ovf_q, 7'(count_q)};
      end else if (readEnable && (readAddr == EventAddr)) begin
         rvalid_d = 1'b1;
         rdata_d  = (count_q != '0) ? {13'b0, mem_q[rd_q]} : 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         pend_q   <= '0;
         kind_q   <= '0;
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         kind_q   <= kind_d;
         mem_q    <= mem_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign readData     = rdata_q;
   assign readValid    = rvalid_q;
   assign eventPending = (count_q != '0);

endmodule

// File: doc/button_event_queue.md
BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

Interface
REQ-001 Parameter DebounceCycles, default 250000, meaning: consecutive stable synchronized cycles before a button level is accepted (10 ms at 25 MHz); minimum 2.
REQ-002 Parameter Depth, default 8, meaning: event FIFO entries, power of two, 2..64.
REQ-003 Parameter BaseAddr, default 16'hFF00, meaning: memory-mapped base; STATUS at BaseAddr, EVENT at BaseAddr+1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 button  input  4  raw asynchronous pushbutton levels, 1 = pressed.
REQ-007 readEnable  input  1  CPU read strobe, one cycle per access.
REQ-008 readAddr  input  16  CPU read address.
REQ-009 readData  output  16  registered read result.
REQ-010 readValid  output  1  high for exactly one cycle when readData carries a decoded read.
REQ-011 writeEnable  input  1  CPU write strobe.
REQ-012 writeAddr  input  16  CPU write address.
REQ-013 writeData  output-side data  input  16  CPU write data.
REQ-014 eventPending  output  1  high while FIFO is non-empty.

Function
REQ-015 Each button bit SHALL pass through a two-flop synchronizer before any other use.
REQ-016 Each button SHALL hold a stable level and a debounce counter; counter clears whenever synchronized level equals stable level, else increments; on reaching DebounceCycles-1 the stable level toggles and the counter clears.
REQ-017 A stable-level toggle SHALL set that button's pending flag, carrying press (0->1) or release (1->0); a second toggle before enqueue overwrites the kind.
REQ-018 At most one pending flag SHALL be enqueued per cycle, lowest button index first; the flag clears on enqueue or on drop.
REQ-019 Event word SHALL be {13'b0, kind, index[1:0]}, kind 1 = press, 0 = release.
REQ-020 Push to a full FIFO SHALL drop the event and set the sticky overflow bit.
REQ-021 Read of EVENT when non-empty SHALL return the oldest event and pop it; when empty SHALL return 16'h0000 with no state change.
REQ-022 Read of STATUS SHALL return {8'b0, overflow, count[6:0]} where count = current FIFO occupancy before any same-cycle push.
REQ-023 readData/readValid SHALL update one cycle after readEnable (1-cycle latency, matching RAM); read of any other address SHALL leave readValid low and readData unchanged.
REQ-024 Simultaneous push and pop SHALL both occur; occupancy unchanged; on a full FIFO the pop frees the slot so the push is accepted.
REQ-025 Write to STATUS with writeData[7]=1 SHALL clear overflow; all other writes SHALL be ignored; a same-cycle overflow set wins over clear.
REQ-026 FIFO pointers SHALL wrap modulo Depth without gaps.

Reset
REQ-027 While rst is high: FIFO empty, overflow 0, all pending flags 0, all stable levels 0 (released), counters 0, synchronizers 0, readData 16'h0000, readValid 0, eventPending 0.
REQ-028 Reset asserted mid-debounce or mid-read SHALL discard the operation; a button held through reset SHALL produce a press event DebounceCycles+2 cycles after rst falls.

Configuration
REQ-029 Macro BUTTON_RELEASE_EVENTS_EN: when defined, release toggles enqueue kind-0 events; when undefined, release toggles update stable level only, never set pending, and kind is always 1.

Verification (DebounceCycles=4, Depth=4)
REQ-030 button[2] held high 20 cycles -> one event 16'h0006 readable; eventPending high; STATUS reads 16'h0001.
REQ-031 button[0] bounces 1/0 every 2 cycles for 12 cycles then stays 0 -> no event; FIFO remains empty; EVENT read returns 16'h0000 with readValid.
REQ-032 buttons 0 and 3 pressed same cycle -> EVENT reads yield 16'h0004 then 16'h0007.
REQ-033 six distinct press/release toggles without reads (macro defined) -> four events retained, STATUS reads 16'h0084; write 16'h0080 to STATUS -> STATUS reads 16'h0004.
REQ-034 FIFO full, EVENT read coincident with new enqueue -> oldest returned, new event accepted, overflow stays 0, count stays 4.
REQ-035 macro undefined, button[1] press then release -> only 16'h0005 queued.
